// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat, 64-bit burst port: stores whole lines
// and answers read/write bursts after a fixed, parameterised latency.
module burst_mem_responder #(
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned LATENCY     = 8,
  parameter int unsigned BEATS       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy,
  output logic        proto_err
);

  localparam int unsigned IW = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  state_t        state;
  logic          is_read;
  logic [IW-1:0] idx;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] beat;
  logic [BW-1:0] next_beat;
  logic          req_held;
  logic          wr_en;
  logic [IW-1:0] req_idx;
  logic [63:0]   store [DEPTH_LINES << BW];
  logic          unused_addr;

  assign req_idx     = mem_addr[5 +: IW];
  assign unused_addr = ^{mem_addr[31:5+IW], mem_addr[4:0]};
  assign next_beat   = beat + BW'(1);
  // Only the latched direction's request keeps a burst alive.
  assign req_held    = is_read ? mem_read : mem_write;
  assign wr_en       = (state == WBURST) && mem_write;

  // Storage has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) store[{idx, beat}] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_read   <= 1'b0;
      idx       <= '0;
      lat_cnt   <= '0;
      beat      <= '0;
      mem_rdata <= '0;
      mem_resp  <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            is_read   <= mem_read;
            idx       <= req_idx;
            beat      <= '0;
            busy      <= 1'b1;
            proto_err <= mem_read && mem_write;
            if (LATENCY == 0) begin
              state     <= mem_read ? RBURST : WBURST;
              mem_resp  <= 1'b1;
              mem_rdata <= mem_read ? store[{req_idx, BW'(0)}] : '0;
            end else begin
              state   <= WAIT;
              lat_cnt <= LW'(LATENCY);
            end
          end
        end
        WAIT: begin
          if (!req_held) begin
            state     <= IDLE;
            busy      <= 1'b0;
            proto_err <= 1'b1;
            lat_cnt   <= '0;
          end else if (lat_cnt == LW'(1)) begin
            lat_cnt   <= '0;
            state     <= is_read ? RBURST : WBURST;
            mem_resp  <= 1'b1;
            mem_rdata <= is_read ? store[{idx, BW'(0)}] : '0;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        RBURST, WBURST: begin
          if (!req_held) begin
            state     <= IDLE;
            busy      <= 1'b0;
            proto_err <= 1'b1;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            beat      <= '0;
          end else if (beat == LAST_BEAT) begin
            state     <= DONE;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            beat      <= '0;
          end else begin
            beat      <= next_beat;
            mem_rdata <= (state == RBURST) ? store[{idx, next_beat}] : '0;
          end
        end
        DONE: begin
          if (!mem_read && !mem_write) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_resp  <= 1'b0;
          mem_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: two instances (LATENCY 8 and 0) checked
// cycle by cycle against a line-array model, directed table plus random bursts.
module tb_burst_mem_responder;

  localparam int DEPTH = 256;
  localparam int BEATS = 4;
  localparam int LAT_A = 8;

  logic        clk;
  logic        rst;
  logic        rd_q    [2];
  logic        wr_q    [2];
  logic [31:0] addr_q  [2];
  logic [63:0] wdata_q [2];
  logic [63:0] rdata0, rdata1;
  logic        resp0, resp1, busy0, busy1, perr0, perr1;

  logic [63:0] model [2][DEPTH][BEATS];
  int checks;
  int errors;

  typedef struct {
    int          u;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    int          drop;
    int          hold;
    bit          exp_err;
  } vec_t;

  burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LAT_A), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .mem_read(rd_q[0]), .mem_write(wr_q[0]),
    .mem_addr(addr_q[0]), .mem_wdata(wdata_q[0]), .mem_rdata(rdata0),
    .mem_resp(resp0), .busy(busy0), .proto_err(perr0)
  );

  burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(0), .BEATS(BEATS)) dut_z (
    .clk(clk), .rst(rst), .mem_read(rd_q[1]), .mem_write(wr_q[1]),
    .mem_addr(addr_q[1]), .mem_wdata(wdata_q[1]), .mem_rdata(rdata1),
    .mem_resp(resp1), .busy(busy1), .proto_err(perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_unit(input int u, input string tag, input logic exp_resp,
                          input logic [63:0] exp_data, input logic exp_busy, input logic exp_err);
    chk({tag, " resp"},  (u == 0) ? resp0  : resp1,  64'(exp_resp));
    chk({tag, " rdata"}, (u == 0) ? rdata0 : rdata1, exp_data);
    chk({tag, " busy"},  (u == 0) ? busy0  : busy1,  64'(exp_busy));
    chk({tag, " perr"},  (u == 0) ? perr0  : perr1,  64'(exp_err));
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with it idle again.
  task automatic burst(input int u, input bit rd, input bit wr, input logic [31:0] addr,
                       input int drop, input int hold, input bit exp_err);
    int lat, idx, b, stop;
    bit isrd, xp_resp;
    logic [63:0] wd [BEATS];
    logic [63:0] xp_data;
    string tag;
    lat  = (u == 0) ? LAT_A : 0;
    idx  = int'((addr >> 5) % DEPTH);
    isrd = rd;
    for (int k = 0; k < BEATS; k++) wd[k] = {$urandom, $urandom};
    rd_q[u] = rd; wr_q[u] = wr; addr_q[u] = addr; wdata_q[u] = wd[0];
    stop = (drop >= 0) ? lat + 2 + drop : lat + BEATS + 2 + hold;
    for (int c = 1; c <= stop; c++) begin
      @(negedge clk);
      b   = c - lat - 1;
      tag = $sformatf("u%0d a%h c%0d", u, addr, c);
      if (c == stop) begin
        chk_unit(u, tag, 1'b0, '0, 1'b0, drop >= 0);
      end else begin
        xp_resp = (b >= 0) && (b < BEATS);
        xp_data = (xp_resp && isrd) ? model[u][idx][b] : '0;
        chk_unit(u, tag, xp_resp, xp_data, 1'b1, exp_err && (c == 1));
        if (xp_resp && !isrd) wdata_q[u] = wd[b];
        if (c == stop - 1) begin
          rd_q[u] = 1'b0;
          wr_q[u] = 1'b0;
        end
      end
    end
    if (!isrd)
      for (int k = 0; k < BEATS; k++)
        if (drop < 0 || k < drop) model[u][idx][k] = wd[k];
  endtask

  vec_t tbl [12];

  initial begin
    checks = 0;
    errors = 0;
    tbl = '{
      '{0, 1'b1, 1'b0, 32'h0000_0040, -1, 0, 1'b0},
      '{0, 1'b0, 1'b1, 32'h1000_0020, -1, 0, 1'b0},
      '{0, 1'b1, 1'b0, 32'h1000_0020, -1, 0, 1'b0},
      '{0, 1'b1, 1'b0, 32'h0000_2020, -1, 0, 1'b0},
      '{1, 1'b1, 1'b0, 32'h0000_0040, -1, 3, 1'b0},
      '{1, 1'b1, 1'b0, 32'h0000_0040, -1, 0, 1'b0},
      '{0, 1'b1, 1'b1, 32'h0000_0060, -1, 0, 1'b1},
      '{0, 1'b1, 1'b0, 32'h0000_0060, -1, 0, 1'b0},
      '{0, 1'b0, 1'b1, 32'h0000_0080,  2, 0, 1'b0},
      '{0, 1'b1, 1'b0, 32'h0000_0080, -1, 1, 1'b0},
      '{1, 1'b0, 1'b1, 32'h0000_00A0,  0, 0, 1'b0},
      '{1, 1'b1, 1'b1, 32'h0000_00A0, -1, 2, 1'b1}
    };
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rd_q[u] = 1'b0; wr_q[u] = 1'b0; addr_q[u] = '0; wdata_q[u] = '0;
    end
    repeat (3) @(negedge clk);
    chk_unit(0, "reset u0", 1'b0, '0, 1'b0, 1'b0);
    chk_unit(1, "reset u1", 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < DEPTH; i++)
        burst(u, 1'b0, 1'b1, 32'(i) << 5, -1, 0, 1'b0);

    for (int i = 0; i < 12; i++)
      burst(tbl[i].u, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].drop, tbl[i].hold, tbl[i].exp_err);

    // Asynchronous reset while beat 2 of a read is on the bus.
    rd_q[0] = 1'b1; addr_q[0] = 32'h0000_0040;
    repeat (LAT_A + 3) @(negedge clk);
    chk("rstseq beat2 resp", 64'(resp0), 64'd1);
    chk("rstseq beat2 rdata", rdata0, model[0][2][2]);
    #2 rst = 1'b1;
    #1;
    chk("rstseq async resp", 64'(resp0), 64'd0);
    chk("rstseq async rdata", rdata0, 64'd0);
    chk("rstseq async busy", 64'(busy0), 64'd0);
    @(negedge clk);
    rd_q[0] = 1'b0;
    rst = 1'b0;
    burst(0, 1'b1, 1'b0, 32'h0000_0040, -1, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int u, kind, drop;
      bit rd, wr;
      u    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      rd   = (kind < 3) || (kind == 5);
      wr   = (kind >= 3);
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
      burst(u, rd, wr, $urandom, drop, int'($urandom_range(0, 2)), rd && wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
